// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fb_writer
//  Purpose  : Packs an 8-bit pixel stream into 32-bit words and writes one
//             frame of NUM_PIXELS/4 words into frame RAM, starting at
//             BASE_ADDR. The first pixel of each word lands in bits [7:0].
//  Revision : 1.0  initial release
// ============================================================================
module fb_writer #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned NUM_PIXELS = 65536,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,      // synchronous, active-low
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [31:0]       data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              err_drop
);

  localparam int unsigned c_num_words = NUM_PIXELS / 4;
  localparam int unsigned c_idx_w     = (c_num_words > 1) ? $clog2(c_num_words) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_words - 1);
  localparam logic [ADDR_W-1:0]  c_base     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           k_q, k_d;          // byte lane of the next pixel
  logic [c_idx_w-1:0]   idx_q, idx_d;      // word index within the frame
  logic [23:0]          lanes_q, lanes_d;  // first three bytes of the word being built
  logic [ADDR_W-1:0]    wraddr_q, wraddr_d;
  logic [31:0]          data_q, data_d;
  logic                 err_q, err_d;

  assign wraddress = wraddr_q;
  assign data      = data_q;
  assign err_drop  = err_q;

  // Next-state and Moore outputs. The RAM address/data registers are loaded on
  // the fourth handshake so they are valid during WRITE and then simply hold.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    idx_d     = idx_q;
    lanes_d   = lanes_q;
    wraddr_d  = wraddr_q;
    data_d    = data_q;
    err_d     = err_q;
    pix_ready = 1'b0;
    wren      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          // A byte offered alongside start is not taken: pix_ready is low here.
          state_d = S_FILL;
          k_d     = 2'd0;
          idx_d   = '0;
        end else if (pix_valid) begin
          err_d = 1'b1;
        end
      end

      S_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          k_d = k_q + 2'd1;
          case (k_q)
            2'd0: lanes_d[7:0]   = pix_data;
            2'd1: lanes_d[15:8]  = pix_data;
            2'd2: lanes_d[23:16] = pix_data;
            default: begin
              data_d   = {pix_data, lanes_q};
              wraddr_d = c_base + ADDR_W'(idx_q);
              state_d  = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        wren = 1'b1;
        if (idx_q == c_last_idx) begin
          // Index saturates at the last word; the frame never writes past it.
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + c_idx_w'(1);
          k_d     = 2'd0;
          state_d = S_FILL;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partially built word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      idx_q    <= '0;
      lanes_q  <= '0;
      wraddr_q <= c_base;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      lanes_q  <= lanes_d;
      wraddr_q <= wraddr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
